// File: rtl/stream_rr_arb.sv
// stream_rr_arb: round-robin N:1 stream arbiter with packet locking
// and a registered output stage.
module stream_rr_arb #(
    parameter int N   = 4,
    parameter int W   = 32,
    parameter int IDW = $clog2(N)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clk_en,
    input  logic [N-1:0]        req_valid,
    output logic [N-1:0]        req_ready,
    input  logic [N-1:0][W-1:0] req_data,
    input  logic [N-1:0]        req_last,
    output logic                o_valid,
    input  logic                o_ready,
    output logic [W-1:0]        o,
    output logic                o_last,
    output logic [IDW-1:0]      o_id
);

    typedef enum logic {
        ST_UNLOCKED,
        ST_LOCKED
    } state_t;

    state_t         state_q, state_d;
    logic [IDW-1:0] prio_q, prio_d;
    logic [IDW-1:0] lock_id_q, lock_id_d;
    logic           o_valid_q, o_valid_d;
    logic [W-1:0]   o_q, o_d;
    logic           o_last_q, o_last_d;
    logic [IDW-1:0] o_id_q, o_id_d;

    logic           locked;
    logic [IDW-1:0] rr_g;
    logic [IDW-1:0] g;
    logic [IDW-1:0] g_inc;
    logic [IDW:0]   cand;
    logic           slot_free;
    logic           acc;

    assign locked = (state_q == ST_LOCKED);

    // Descending scan so the lowest rotated offset wins.
    always_comb begin
        rr_g = prio_q;
        cand = '0;
        for (int k = N - 1; k >= 0; k--) begin
            cand = {1'b0, prio_q} + (IDW+1)'(k);
            if (cand >= (IDW+1)'(N)) begin
                cand = cand - (IDW+1)'(N);
            end
            if (req_valid[cand[IDW-1:0]]) begin
                rr_g = cand[IDW-1:0];
            end
        end
    end

    assign g         = locked ? lock_id_q : rr_g;
    assign g_inc     = (g == IDW'(N - 1)) ? '0 : g + 1'b1;
    assign slot_free = !o_valid_q || o_ready;

    always_comb begin
        req_ready = '0;
        for (int j = 0; j < N; j++) begin
            req_ready[j] = rst_n && clk_en && slot_free
                         && (g == IDW'(j))
                         && (locked || req_valid[j]);
        end
    end

    assign acc = req_valid[g] && req_ready[g];

    always_comb begin
        state_d   = state_q;
        prio_d    = prio_q;
        lock_id_d = lock_id_q;
        o_valid_d = o_valid_q;
        o_d       = o_q;
        o_last_d  = o_last_q;
        o_id_d    = o_id_q;
        if (clk_en) begin
            if (acc) begin
                o_valid_d = 1'b1;
                o_d       = req_data[g];
                o_last_d  = req_last[g];
                o_id_d    = g;
                if (req_last[g]) begin
                    state_d = ST_UNLOCKED;
                    prio_d  = g_inc;
                end else begin
                    state_d   = ST_LOCKED;
                    lock_id_d = g;
                end
            end else if (o_ready) begin
                o_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_UNLOCKED;
            prio_q    <= '0;
            lock_id_q <= '0;
            o_valid_q <= 1'b0;
            o_q       <= '0;
            o_last_q  <= 1'b0;
            o_id_q    <= '0;
        end else begin
            state_q   <= state_d;
            prio_q    <= prio_d;
            lock_id_q <= lock_id_d;
            o_valid_q <= o_valid_d;
            o_q       <= o_d;
            o_last_q  <= o_last_d;
            o_id_q    <= o_id_d;
        end
    end

    assign o_valid = o_valid_q;
    assign o       = o_q;
    assign o_last  = o_last_q;
    assign o_id    = o_id_q;

endmodule

// File: tb/tb_stream_rr_arb.sv
// tb_stream_rr_arb: directed checks of stream_rr_arb with N=4, W=32.
// Inputs change 1 time unit after each rising edge; outputs sampled there.
module tb_stream_rr_arb;

    localparam int N   = 4;
    localparam int W   = 32;
    localparam int IDW = 2;

    logic                clk;
    logic                rst_n;
    logic                clk_en;
    logic [N-1:0]        req_valid;
    logic [N-1:0]        req_ready;
    logic [N-1:0][W-1:0] req_data;
    logic [N-1:0]        req_last;
    logic                o_valid;
    logic                o_ready;
    logic [W-1:0]        o;
    logic                o_last;
    logic [IDW-1:0]      o_id;

    int n_pass;
    int n_total;

    stream_rr_arb #(.N(N), .W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clk_en    (clk_en),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_data  (req_data),
        .req_last  (req_last),
        .o_valid   (o_valid),
        .o_ready   (o_ready),
        .o         (o),
        .o_last    (o_last),
        .o_id      (o_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        n_pass    = 0;
        n_total   = 0;
        rst_n     = 1'b0;
        clk_en    = 1'b1;
        req_valid = 4'b0001;
        req_data  = '0;
        req_last  = '0;
        o_ready   = 1'b1;
        tick();
        tick();

        // Reset state
        chk("rst_o_valid", 32'(o_valid), 32'd0);
        chk("rst_o", o, 32'd0);
        chk("rst_o_id", 32'(o_id), 32'd0);
        chk("rst_o_last", 32'(o_last), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_prio", 32'(dut.prio_q), 32'd0);
        chk("rst_locked", 32'(dut.locked), 32'd0);

        // Basic single beat from requester 2
        rst_n       = 1'b1;
        req_valid   = 4'b0100;
        req_data[2] = 32'hA5;
        req_last    = 4'b1111;
        settle();
        chk("basic_ready", 32'(req_ready), 32'b0100);
        tick();
        req_valid = 4'b0000;
        chk("basic_valid", 32'(o_valid), 32'd1);
        chk("basic_o", o, 32'hA5);
        chk("basic_id", 32'(o_id), 32'd2);
        chk("basic_last", 32'(o_last), 32'd1);
        chk("basic_prio", 32'(dut.prio_q), 32'd3);
        tick();
        chk("basic_drain", 32'(o_valid), 32'd0);

        // Round robin from a fresh reset
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int j = 0; j < N; j++) req_data[j] = 32'h10 + 32'(j);
        req_valid = 4'b1111;
        for (int i = 0; i < 16; i++) begin
            tick();
            chk("rr_id", 32'(o_id), 32'(i % 4));
            chk("rr_o", o, 32'h10 + 32'(i % 4));
            chk("rr_valid", 32'(o_valid), 32'd1);
        end
        req_valid = 4'b0000;
        tick();
        chk("rr_drain", 32'(o_valid), 32'd0);
        chk("rr_prio", 32'(dut.prio_q), 32'd0);

        // Move prio to 1 so requester 1 starts before requester 0
        req_valid   = 4'b0001;
        req_data[0] = 32'hB0;
        tick();
        chk("pre_lock_id", 32'(o_id), 32'd0);
        chk("pre_lock_prio", 32'(dut.prio_q), 32'd1);

        // Three-beat packet from requester 1 with a valid gap
        req_valid   = 4'b0011;
        req_last    = 4'b0001;
        req_data[1] = 32'hB1;
        settle();
        chk("lock_rdy1", 32'(req_ready), 32'b0010);
        tick();
        chk("lock_id1", 32'(o_id), 32'd1);
        chk("lock_o1", o, 32'hB1);
        chk("lock_locked1", 32'(dut.locked), 32'd1);
        req_data[1] = 32'hB2;
        settle();
        chk("lock_rdy2", 32'(req_ready), 32'b0010);
        tick();
        chk("lock_id2", 32'(o_id), 32'd1);
        chk("lock_o2", o, 32'hB2);
        req_valid = 4'b0001;
        settle();
        chk("lock_gap_rdy", 32'(req_ready), 32'b0010);
        tick();
        chk("lock_gap_valid", 32'(o_valid), 32'd0);
        chk("lock_gap_locked", 32'(dut.locked), 32'd1);
        req_valid   = 4'b0011;
        req_data[1] = 32'hB3;
        req_last    = 4'b0011;
        settle();
        chk("lock_rdy3", 32'(req_ready), 32'b0010);
        tick();
        chk("lock_id3", 32'(o_id), 32'd1);
        chk("lock_o3", o, 32'hB3);
        chk("lock_last3", 32'(o_last), 32'd1);
        chk("lock_unlocked", 32'(dut.locked), 32'd0);
        chk("lock_prio", 32'(dut.prio_q), 32'd2);
        req_valid = 4'b0001;
        settle();
        chk("post_lock_rdy", 32'(req_ready), 32'b0001);
        tick();
        chk("post_lock_id", 32'(o_id), 32'd0);
        chk("post_lock_o", o, 32'hB0);
        req_valid = 4'b0000;
        tick();

        // Backpressure
        req_last    = 4'b1111;
        req_valid   = 4'b0110;
        req_data[1] = 32'hC1;
        req_data[2] = 32'hC2;
        o_ready     = 1'b0;
        settle();
        chk("bp_rdy0", 32'(req_ready), 32'b0010);
        tick();
        req_valid = 4'b0100;
        chk("bp_o0", o, 32'hC1);
        for (int i = 0; i < 5; i++) begin
            settle();
            chk("bp_hold_rdy", 32'(req_ready), 32'd0);
            chk("bp_hold_valid", 32'(o_valid), 32'd1);
            chk("bp_hold_o", o, 32'hC1);
            chk("bp_hold_id", 32'(o_id), 32'd1);
            tick();
        end
        o_ready = 1'b1;
        settle();
        chk("bp_rel_rdy", 32'(req_ready), 32'b0100);
        tick();
        req_valid = 4'b0000;
        chk("bp_rel_o", o, 32'hC2);
        chk("bp_rel_id", 32'(o_id), 32'd2);
        chk("bp_rel_valid", 32'(o_valid), 32'd1);
        tick();
        chk("bp_drain", 32'(o_valid), 32'd0);
        chk("bp_prio", 32'(dut.prio_q), 32'd3);

        // Clock enable freeze mid-stream
        req_valid = 4'b1111;
        tick();
        chk("ce_id_a", 32'(o_id), 32'd3);
        tick();
        chk("ce_id_b", 32'(o_id), 32'd0);
        clk_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("ce_rdy", 32'(req_ready), 32'd0);
            tick();
            chk("ce_hold_id", 32'(o_id), 32'd0);
            chk("ce_hold_valid", 32'(o_valid), 32'd1);
            chk("ce_hold_prio", 32'(dut.prio_q), 32'd1);
        end
        clk_en = 1'b1;
        tick();
        chk("ce_resume_a", 32'(o_id), 32'd1);
        tick();
        chk("ce_resume_b", 32'(o_id), 32'd2);
        req_valid = 4'b0000;
        tick();
        chk("ce_prio", 32'(dut.prio_q), 32'd3);

        // Reset while locked on requester 3
        req_valid   = 4'b1000;
        req_last    = 4'b0000;
        req_data[3] = 32'hD1;
        tick();
        chk("rl_id1", 32'(o_id), 32'd3);
        req_data[3] = 32'hD2;
        tick();
        chk("rl_id2", 32'(o_id), 32'd3);
        chk("rl_locked", 32'(dut.locked), 32'd1);
        req_valid   = 4'b1001;
        req_last    = 4'b0001;
        req_data[0] = 32'hE0;
        rst_n       = 1'b0;
        settle();
        chk("rl_rst_rdy", 32'(req_ready), 32'd0);
        tick();
        chk("rl_valid", 32'(o_valid), 32'd0);
        chk("rl_unlocked", 32'(dut.locked), 32'd0);
        chk("rl_prio", 32'(dut.prio_q), 32'd0);
        rst_n = 1'b1;
        settle();
        chk("rl_next_rdy", 32'(req_ready), 32'b0001);
        tick();
        chk("rl_next_id", 32'(o_id), 32'd0);
        chk("rl_next_o", o, 32'hE0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/stream_rr_arb.md
# stream_rr_arb

Round-robin arbiter that shares one valid-ready stream (typically a `fifo` input or a shared CFU request port) among N requesters. Multi-beat packets are delimited by a `last` flag and never interleaved: once a requester's first beat is accepted, it holds the grant until its `last` beat. The output is a registered stream stage, so `o_valid`, `o`, `o_last`, and `o_id` all come from flops. Sits between per-hart or per-lane request streams and a single downstream queue or CFU.

## Interface
- `N`, default 4: number of requesters. Range 2..16.
- `W`, default 32: data width.
- `IDW`, default `$clog2(N)`: width of the requester ID.

- `clk`  in  1  clock
- `rst_n`  in  1  reset; synchronous, active-low
- `clk_en`  in  1  clock enable; when low, all state holds
- `req_valid`  in  N  per-requester valid
- `req_ready`  out  N  per-requester ready; combinational
- `req_data`  in  N×W  per-requester data, packed `[N-1:0][W-1:0]`
- `req_last`  in  N  per-requester end-of-packet flag
- `o_valid`  out  1  output valid; registered
- `o_ready`  in  1  downstream ready
- `o`  out  W  output data; registered
- `o_last`  out  1  output end-of-packet; registered
- `o_id`  out  IDW  index of the requester that sourced `o`; registered

## Operation
- Single clock domain. Reset is synchronous and active-low.
- State:
  - `prio` (IDW bits): the highest-priority index.
  - `locked` (1 bit).
  - `lock_id` (IDW bits).
  - The output register: `o_valid`, `o`, `o_last`, `o_id`.
- Two arbitration states:
  - UNLOCKED: grant `g` = the first index `j` with `req_valid[j]`, searching `prio, prio+1, … N-1, 0, … prio-1`. Arithmetic is mod N (this also holds for non-power-of-2 N).
  - LOCKED: `g = lock_id`. Only that requester is considered; all other requests are ignored.
- `slot_free = !o_valid || o_ready`.
- `req_ready[j] = clk_en && slot_free && (j == g) && (LOCKED || req_valid[j])`. At most one bit of `req_ready` is high per cycle. In LOCKED state, `req_ready[lock_id]` may be high while that requester's valid is low.
- Accept: `acc = req_valid[g] && req_ready[g]`. On accept, `{o, o_last, o_id} <= {req_data[g], req_last[g], g}` and `o_valid <= 1`.
- State transitions on accept:
  - If `req_last[g]` is 1: go to (or stay) UNLOCKED and set `prio <= (g+1) mod N`.
  - Otherwise: `locked <= 1` and `lock_id <= g`. `prio` is unchanged.
- With no accept and `o_ready` high, `o_valid <= 0`. With no accept and `o_ready` low, `o_valid` holds.
- An idle cycle with no valid requests changes neither `prio` nor `locked`.
- A locked requester that deasserts `req_valid` mid-packet keeps the lock indefinitely. No timeout.
- Fairness: a continuously valid requester is granted within N-1 other packets.
- With `clk_en` low:
  - No state changes.
  - All `req_ready` bits are 0.
  - Outputs hold their values.

## Timing
- Reset values:
  - `o_valid` = 0, `o_last` = 0, `o_id` = 0, `o` = 0.
  - `prio` = 0, `locked` = 0, `lock_id` = 0.
  - `req_ready` = 0 while `rst_n` is low.
- Latency: a beat accepted at edge k is presented on `o` after edge k, i.e. visible in cycle k+1.
- Throughput: one beat per cycle when `o_ready` is held high. Back-to-back beats from different requesters need no bubble.
- Simultaneous `o_ready` and accept: the output register is replaced in the same edge. No loss and no duplication.
- Packet handover: the edge that accepts a `last` beat also rotates `prio`. The next cycle's grant already uses the new `prio`.
- Reset mid-packet: the lock is cleared and `o_valid` drops on the reset edge. The partial packet is abandoned, with no recovery.
- `o_valid`, `o`, `o_last`, and `o_id` must not change while `o_valid && !o_ready` and `clk_en` is high.

## Test plan
- Basic path and reset: reset, then requester 2 sends a single beat (`data=0xA5`, `last=1`) with `o_ready=1`.
  - Required: `o_valid=1`, `o=0xA5`, `o_id=2` one cycle after the accept.
  - Required: `prio=3` afterwards.
  - Required: all outputs are 0 during reset.
- Round-robin rotation: N=4, all requesters continuously valid with single-beat packets, `o_ready=1`.
  - Required: `o_id` sequence 0,1,2,3,0,1,… with no gaps over 16 cycles.
- Packet lock: requester 1 sends 3 beats (`last` on the 3rd) while requester 0 is valid throughout.
  - Required: `o_id` = 1,1,1, then 0.
  - Required: `req_ready[0]=0` during the whole packet.
  - Required: a mid-packet valid gap on requester 1 keeps the lock.
- Backpressure: hold `o_ready=0` for 5 cycles with requesters valid.
  - Required: outputs are stable and exactly one beat is buffered.
  - Required: `req_ready=0` while `o_valid` is high.
  - Required: when `o_ready` is released, beats continue at one per cycle with no loss or duplication (scoreboard check).
- Clock enable: drop `clk_en` for 3 cycles mid-stream.
  - Required: `req_ready=0`, and state and outputs are frozen.
  - Required: the stream resumes in identical order.
- Reset while LOCKED mid-packet (requester 3, after 2 beats).
  - Required: next cycle has `o_valid=0`, `locked=0`, `prio=0`.
  - Required: the following grant goes to requester 0 if it is valid.
